// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution, PC redirect, flush control and 2-bit BHT
// Optional feature macro: BRANCH_STATS_EN (adds stat_branches / stat_mispredicts counters)

module branch_resolve #(
    parameter int XLEN         = 32,
    parameter int BHT_IDX_BITS = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_pred_taken,
    output logic            BrUn,
    input  logic            BrEq,
    input  logic            BrLT,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            stall_ex,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam int CNT_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int FLUSH_LOAD  = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [XLEN-1:0]         redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic [1:0]              bht_q [BHT_ENTRIES];
    logic [1:0]              bht_d [BHT_ENTRIES];

    logic                    taken;
    logic                    legal;
    logic                    resolve;
    logic                    is_jump;
    logic                    br_res;
    logic                    mispredict;
    logic [BHT_IDX_BITS-1:0] ex_idx;
    logic [BHT_IDX_BITS-1:0] if_idx;
    logic [XLEN-1:0]         pc_plus_imm;
    logic [XLEN-1:0]         pc_plus_4;
    logic [XLEN-1:0]         rs1_plus_imm;
    logic                    unused_if_pc;

    assign BrUn         = ex_funct3[1];
    assign pc_plus_imm  = ex_pc + ex_imm;
    assign pc_plus_4    = ex_pc + XLEN'(4);
    assign rs1_plus_imm = ex_rs1 + ex_imm;
    assign ex_idx       = ex_pc[BHT_IDX_BITS+1:2];
    assign if_idx       = if_pc[BHT_IDX_BITS+1:2];
    assign unused_if_pc = ^if_pc;

    // Branch condition decode; funct3 010/011 are not branches and are flagged illegal.
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            3'b000:  taken = BrEq;
            3'b001:  taken = !BrEq;
            3'b100:  taken = BrLT;
            3'b101:  taken = !BrLT;
            3'b110:  taken = BrLT;
            3'b111:  taken = !BrLT;
            default: legal = 1'b0;
        endcase
    end

    assign resolve    = (state_q == S_IDLE) && ex_valid;
    assign is_jump    = ex_is_jal || ex_is_jalr;
    assign br_res     = resolve && ex_is_branch && legal;
    assign mispredict = br_res && (taken != ex_pred_taken);

    // Redirect/flush FSM next state; jumps take priority over branch mispredicts.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        flush_cnt_d   = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (resolve && is_jump) begin
                    redirect_pc_d = ex_is_jal ? pc_plus_imm : {rs1_plus_imm[XLEN-1:1], 1'b0};
                    state_d       = S_REDIRECT;
                end else if (mispredict) begin
                    redirect_pc_d = taken ? pc_plus_imm : pc_plus_4;
                    state_d       = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        flush_cnt_d = FLUSH_LOAD[CNT_W-1:0];
                        state_d     = S_FLUSH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // BHT saturating-counter update for legal branches resolved in IDLE.
    always_comb begin
        bht_d = bht_q;
        if (br_res) begin
            if (taken && (bht_q[ex_idx] != 2'b11)) begin
                bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            end else if (!taken && (bht_q[ex_idx] != 2'b00)) begin
                bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
            end
        end
    end

    // State, redirect target, flush counter and BHT registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            redirect_pc_q <= '0;
            flush_cnt_q   <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            flush_cnt_q   <= flush_cnt_d;
            bht_q         <= bht_d;
        end
    end

    assign redirect_valid = (state_q == S_REDIRECT);
    assign stall_ex       = (state_q == S_REDIRECT);
    assign flush          = (state_q != S_IDLE);
    assign redirect_pc    = redirect_pc_q;
    assign if_pred_taken  = bht_q[if_idx][1];

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    // Saturating resolution and mispredict counters; jumps are excluded.
    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (br_res && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (mispredict && (stat_mis_q != 32'hFFFF_FFFF)) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard testbench for branch_resolve

module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        ex_pred_taken;
    logic        BrUn, BrEq, BrLT;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush, stall_ex;
    logic [31:0] if_pc;
    logic        if_pred_taken;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_pred_taken  (ex_pred_taken),
        .BrUn           (BrUn),
        .BrEq           (BrEq),
        .BrLT           (BrLT),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stall_ex       (stall_ex),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Redirect monitor: every accepted redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (reset_n && redirect_valid && redirect_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_redirect: got %h expected none", redirect_pc);
            end else begin
                chk("redirect_pc_handshake", redirect_pc, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 3'b000; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
        ex_pred_taken = 0; BrEq = 0; BrLT = 0;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                            input logic eq, input logic lt, input logic pred);
        clear_ex();
        ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_imm = imm;
        ex_funct3 = f3; BrEq = eq; BrLT = lt; ex_pred_taken = pred;
    endtask

    task automatic wait_idle();
        int n;
        redirect_ready = 1;
        n = 0;
        while ((flush || redirect_valid) && n < 12) begin
            tick();
            n++;
        end
        chk("return_to_idle", {31'd0, flush | redirect_valid}, 32'd0);
    endtask

    task automatic run_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                          input logic eq, input logic lt, input logic pred,
                          input logic exp_brun, input logic exp_redir, input logic [31:0] exp_tgt);
        drive_br(pc, imm, f3, eq, lt, pred);
        #1;
        chk("brun", {31'd0, BrUn}, {31'd0, exp_brun});
        if (exp_redir) exp_q.push_back(exp_tgt);
        tick();
        clear_ex();
        chk("redirect_valid_after_resolve", {31'd0, redirect_valid}, {31'd0, exp_redir});
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0;
        clear_ex();
        redirect_ready = 1;
        if_pc = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        #1;
        chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_stall", {31'd0, stall_ex}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_bht", {31'd0, if_pred_taken}, 32'd0);

        // BEQ taken, predicted not-taken
        if_pc = 32'h100;
        drive_br(32'h100, 32'h20, 3'b000, 1, 0, 0);
        #1;
        chk("beq_brun", {31'd0, BrUn}, 32'd0);
        chk("beq_same_cycle_lookup", {31'd0, if_pred_taken}, 32'd0);
        exp_q.push_back(32'h120);
        tick();
        clear_ex();
        chk("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_flush", {31'd0, flush}, 32'd1);
        chk("beq_stall", {31'd0, stall_ex}, 32'd1);
        chk("beq_bht_updated", {31'd0, if_pred_taken}, 32'd1);
        tick();
        chk("flush1_valid", {31'd0, redirect_valid}, 32'd0);
        chk("flush1_flush", {31'd0, flush}, 32'd1);
        chk("flush1_stall", {31'd0, stall_ex}, 32'd0);
        tick();
        chk("flush2_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("idle_flush", {31'd0, flush}, 32'd0);
        chk("idle_valid", {31'd0, redirect_valid}, 32'd0);

        // BGEU taken, predicted taken: no redirect
        if_pc = 32'h200;
        drive_br(32'h200, 32'h80, 3'b111, 0, 0, 1);
        #1;
        chk("bgeu_brun", {31'd0, BrUn}, 32'd1);
        tick();
        clear_ex();
        chk("bgeu_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("bgeu_no_flush", {31'd0, flush}, 32'd0);
        chk("bgeu_bht", {31'd0, if_pred_taken}, 32'd1);

        // BNE mispredict with fetch back-pressure; ex branch meanwhile must be ignored
        redirect_ready = 0;
        drive_br(32'h300, 32'h40, 3'b001, 0, 0, 0);
        exp_q.push_back(32'h340);
        tick();
        clear_ex();
        for (int i = 0; i < 5; i++) begin
            chk("bne_hold_valid", {31'd0, redirect_valid}, 32'd1);
            chk("bne_hold_pc", redirect_pc, 32'h340);
            if (i == 1) drive_br(32'h104, 32'h10, 3'b000, 1, 0, 1);
            if (i == 3) clear_ex();
            tick();
        end
        if_pc = 32'h104;
        #1;
        chk("ignored_branch_bht", {31'd0, if_pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("stat_branches_3", stat_branches, 32'd3);
        chk("stat_mispredicts_2", stat_mispredicts, 32'd2);
`endif
        wait_idle();

        // Remaining funct3 encodings, negative offset and address wrap
        run_br(32'h500, 32'h8, 3'b100, 0, 1, 0, 0, 1, 32'h508);
        run_br(32'h600, 32'h8, 3'b101, 0, 1, 1, 0, 1, 32'h604);
        run_br(32'h900, 32'h8, 3'b110, 0, 0, 0, 1, 0, 32'h0);
        run_br(32'h700, 32'h8, 3'b000, 0, 0, 1, 0, 1, 32'h704);
        run_br(32'hA00, 32'h8, 3'b001, 1, 0, 0, 0, 0, 32'h0);
        run_br(32'h800, 32'hFFFF_FFF0, 3'b101, 0, 0, 0, 0, 1, 32'h7F0);
        run_br(32'hFFFF_FFF0, 32'h20, 3'b100, 0, 1, 0, 0, 1, 32'h10);

        // JALR clears bit 0; JAL with negative offset
        clear_ex();
        ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h2000; ex_rs1 = 32'h1001; ex_imm = 32'h6;
        exp_q.push_back(32'h1006);
        tick();
        clear_ex();
        chk("jalr_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        wait_idle();
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h3000; ex_imm = 32'hFFFF_F000;
        exp_q.push_back(32'h2000);
        tick();
        clear_ex();
        chk("jal_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        wait_idle();

        // BHT saturation on one index
        if_pc = 32'h108;
        for (int i = 0; i < 4; i++) begin
            drive_br(32'h108, 32'h4, 3'b000, 1, 0, 1);
            tick();
        end
        clear_ex();
        chk("sat_taken", {31'd0, if_pred_taken}, 32'd1);
        chk("sat_no_redirect", {31'd0, redirect_valid}, 32'd0);
        drive_br(32'h108, 32'h4, 3'b000, 0, 0, 0);
        tick();
        clear_ex();
        chk("sat_dec_11_10", {31'd0, if_pred_taken}, 32'd1);
        drive_br(32'h108, 32'h4, 3'b000, 0, 0, 0);
        tick();
        clear_ex();
        chk("sat_dec_10_01", {31'd0, if_pred_taken}, 32'd0);

        // Illegal funct3
        if_pc = 32'h10C;
        drive_br(32'h10C, 32'h40, 3'b010, 1, 0, 1);
        #1;
        chk("illegal_brun", {31'd0, BrUn}, 32'd1);
        tick();
        clear_ex();
        chk("illegal_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("illegal_bht_unchanged", {31'd0, if_pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("stat_branches_16", stat_branches, 32'd16);
        chk("stat_mispredicts_7", stat_mispredicts, 32'd7);
`endif

        // Asynchronous reset while a redirect is pending
        redirect_ready = 0;
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h400; ex_imm = 32'h10;
        tick();
        clear_ex();
        chk("pre_reset_valid", {31'd0, redirect_valid}, 32'd1);
        #2;
        reset_n = 0;
        #1;
        chk("async_reset_valid", {31'd0, redirect_valid}, 32'd0);
        chk("async_reset_flush", {31'd0, flush}, 32'd0);
        chk("async_reset_stall", {31'd0, stall_ex}, 32'd0);
        chk("async_reset_pc", redirect_pc, 32'd0);
        for (int i = 0; i < 64; i++) begin
            if_pc = i << 2;
            #1;
            chk("reset_bht_entry", {31'd0, if_pred_taken}, 32'd0);
        end
`ifdef BRANCH_STATS_EN
        chk("reset_stat_branches", stat_branches, 32'd0);
        chk("reset_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        reset_n = 1;
        redirect_ready = 1;
        tick();
        chk("post_reset_no_redirect", {31'd0, redirect_valid}, 32'd0);
        if_pc = 32'h108;
        drive_br(32'h108, 32'h4, 3'b000, 1, 0, 1);
        tick();
        clear_ex();
        chk("reset_bht_weak_nt", {31'd0, if_pred_taken}, 32'd1);

        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
